// File: rtl/ticket_pkg.sv
// Shared types and constants for the ticket vendor: FSM states and bill unit values.
package ticket_pkg;

    typedef logic [2:0] units_t;

    typedef enum logic [1:0] {
        StReady,
        StBill,
        StDispense,
        StChange
    } state_e;

    localparam units_t TEN_UNITS    = 3'd1;
    localparam units_t TWENTY_UNITS = 3'd2;
    localparam units_t FIFTY_UNITS  = 3'd5;

endpackage

// File: rtl/ticket_vendor_if.sv
// Bill validator / dispenser-side signal bundle for the ticket vendor.
// Error exists only when TICKET_MULTIBILL_ERR_EN is defined.
interface ticket_vendor_if #(
    parameter int unsigned CREDIT_W = 4
);
    logic                ten;
    logic                twenty;
    logic                fifty;
    logic                cancel;
    logic                ready;
    logic                bill;
    logic                dispense;
    logic                change;
    logic [CREDIT_W-1:0] credit;
`ifdef TICKET_MULTIBILL_ERR_EN
    logic                error;

    modport master (
        output ten, twenty, fifty, cancel,
        input  ready, bill, dispense, change, credit, error
    );
    modport slave (
        input  ten, twenty, fifty, cancel,
        output ready, bill, dispense, change, credit, error
    );
`else
    modport master (
        output ten, twenty, fifty, cancel,
        input  ready, bill, dispense, change, credit
    );
    modport slave (
        input  ten, twenty, fifty, cancel,
        output ready, bill, dispense, change, credit
    );
`endif
endinterface

// File: rtl/ticket_bill_decode.sv
// Combinational bill strobe decoder: one-hot check, multi-bill flag and unit value.
module ticket_bill_decode
    import ticket_pkg::*;
(
    input  logic   ten_i,
    input  logic   twenty_i,
    input  logic   fifty_i,
    output logic   valid_o,
    output logic   multi_o,
    output units_t units_o
);

    always_comb begin
        valid_o = 1'b0;
        multi_o = 1'b0;
        units_o = '0;
        case ({ten_i, twenty_i, fifty_i})
            3'b000: ;
            3'b100: begin
                valid_o = 1'b1;
                units_o = TEN_UNITS;
            end
            3'b010: begin
                valid_o = 1'b1;
                units_o = TWENTY_UNITS;
            end
            3'b001: begin
                valid_o = 1'b1;
                units_o = FIFTY_UNITS;
            end
            default: multi_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ticket_vendor.sv
// Ticket vendor FSM: accumulates bill credit, dispenses one ticket and pays change
// one unit per cycle. Optional multi-bill Error output under TICKET_MULTIBILL_ERR_EN.
module ticket_vendor
    import ticket_pkg::*;
#(
    parameter int unsigned PRICE    = 4,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    ticket_vendor_if.slave  vend_io
);

    localparam logic [CREDIT_W-1:0] PriceW = CREDIT_W'(PRICE);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;

    logic                dec_valid;
    logic                dec_multi;
    units_t              dec_units;
    logic [CREDIT_W-1:0] units_w;
    logic [CREDIT_W-1:0] bill_sum;

    ticket_bill_decode u_decode (
        .ten_i    (vend_io.ten),
        .twenty_i (vend_io.twenty),
        .fifty_i  (vend_io.fifty),
        .valid_o  (dec_valid),
        .multi_o  (dec_multi),
        .units_o  (dec_units)
    );

    // Zero when no single bill is present, so cancel can add it unconditionally.
    assign units_w  = dec_valid ? CREDIT_W'(dec_units) : '0;
    assign bill_sum = credit_q + units_w;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        unique case (state_q)
            StReady: begin
                if (dec_valid) begin
                    credit_d = units_w;
                    state_d  = (units_w < PriceW) ? StBill : StDispense;
                end
            end
            StBill: begin
                if (vend_io.cancel) begin
                    credit_d = bill_sum;
                    state_d  = StChange;
                end else if (dec_valid) begin
                    credit_d = bill_sum;
                    state_d  = (bill_sum < PriceW) ? StBill : StDispense;
                end
            end
            StDispense: begin
                credit_d = credit_q - PriceW;
                state_d  = (credit_d != '0) ? StChange : StReady;
            end
            StChange: begin
                credit_d = credit_q - CREDIT_W'(1);
                state_d  = (credit_d == '0) ? StReady : StChange;
            end
            default: begin
                state_d  = StReady;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StReady;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    assign vend_io.ready    = (state_q == StReady);
    assign vend_io.bill     = (state_q == StBill);
    assign vend_io.dispense = (state_q == StDispense);
    assign vend_io.change   = (state_q == StChange);
    assign vend_io.credit   = credit_q;

`ifdef TICKET_MULTIBILL_ERR_EN
    logic error_q, error_d;

    assign error_d = dec_multi && ((state_q == StReady) || (state_q == StBill));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign vend_io.error = error_q;
`else
    logic unused_multi;
    assign unused_multi = dec_multi;
`endif

endmodule
